// File: rtl/sort_pkg.sv
// sort_pkg: shared types, widths and sizing helper for the comparator-based sorter.
package sort_pkg;
    typedef enum logic [1:0] {IDLE, SORT, DONE} sort_state_t;
    localparam int CMP_W = 4;
    function automatic int max_cmp(input int n);
        return n * (n - 1) / 2;
    endfunction
endpackage

// File: rtl/cmp_sort_sequencer_if.sv
// cmp_sort_sequencer_if: request/result bundle between the sorter and its user.
interface cmp_sort_sequencer_if
    import sort_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(max_cmp(N) + 1)
);
    logic                 start;
    logic [N*CMP_W-1:0]   data_in;
    logic                 busy;
    logic                 done;
    logic [N*CMP_W-1:0]   data_out;
    logic [CNT_W-1:0]     swap_count;
    modport master(output start, data_in, input busy, done, data_out, swap_count);
    modport slave(input start, data_in, output busy, done, data_out, swap_count);
endinterface

// File: rtl/Comparator.sv
// Comparator: unsigned 4-bit magnitude compare, the shared resource the sorter schedules.
module Comparator
    import sort_pkg::*;
(
    input  logic [CMP_W-1:0] A,
    input  logic [CMP_W-1:0] B,
    output logic             A_greater_B,
    output logic             A_equal_B,
    output logic             A_lesser_B
);
    assign A_greater_B = A > B;
    assign A_equal_B   = A == B;
    assign A_lesser_B  = A < B;
endmodule

// File: rtl/cmp_sort_sequencer.sv
// cmp_sort_sequencer: early-exit bubble sort, one adjacent compare/swap per cycle
// through a single shared Comparator.
module cmp_sort_sequencer
    import sort_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(max_cmp(N) + 1)
) (
    input logic                 clk,
    input logic                 rst,
    cmp_sort_sequencer_if.slave bus
);
    localparam int J_W = $clog2(N);
    localparam logic [J_W-1:0] ONE  = J_W'(1);
    localparam logic [J_W-1:0] LAST = J_W'(N - 2);
    sort_state_t       state;
    logic [CMP_W-1:0]  arr [N];
    logic [J_W-1:0]    j, pass, j_nxt;
    logic              swapped, busy, done;
    logic [CNT_W-1:0]  swap_count;
    logic [CMP_W-1:0]  a, b;
    logic              gt, eq, lt, swap, end_pass;
    assign j_nxt    = j + ONE;
    assign a        = arr[j];
    assign b        = arr[j_nxt];
    assign swap     = gt & ~(eq | lt);
    assign end_pass = j == LAST - pass;
    Comparator u_cmp (
        .A           (a),
        .B           (b),
        .A_greater_B (gt),
        .A_equal_B   (eq),
        .A_lesser_B  (lt)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            for (int i = 0; i < N; i++) arr[i] <= '0;
            j          <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    for (int i = 0; i < N; i++) arr[i] <= bus.data_in[i*CMP_W +: CMP_W];
                    j          <= '0;
                    pass       <= '0;
                    swapped    <= 1'b0;
                    swap_count <= '0;
                    busy       <= 1'b1;
                    state      <= SORT;
                end
                SORT: begin
                    if (swap) begin
                        arr[j]     <= b;
                        arr[j_nxt] <= a;
                        swap_count <= swap_count + CNT_W'(1);
                    end
                    // the current cycle's swap counts toward the early-exit decision
                    if (!end_pass) begin
                        j       <= j_nxt;
                        swapped <= swapped | swap;
                    end else if (!(swapped || swap) || pass == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        pass    <= pass + ONE;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_out
        assign bus.data_out[g*CMP_W +: CMP_W] = arr[g];
    end
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.swap_count = swap_count;
endmodule
